// File: rtl/pingpong_ctrl.sv
// Ping-pong sample buffer sequencer: fills one bank per frame, swaps banks when the
// reader is free, and sweeps the full bank out with RD_LAT-aligned valid/last.
module pingpong_ctrl #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid_i,
  input  logic [DATA_BITS-1:0] sample_i,
  output logic [DATA_BITS-1:0] buff_wdata_o,
  output logic [ADDR_BITS-1:0] buff_waddr_o,
  output logic                 buff_wren_o,
  output logic                 buff_sel_o,
  output logic [ADDR_BITS-1:0] buff_raddr_o,
  input  logic [DATA_BITS-1:0] buff_rdata_i,
  input  logic                 rd_start_i,
  output logic                 frame_ready_o,
  output logic                 rd_busy_o,
  output logic                 rd_valid_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_last_o,
  output logic                 overrun_o,
  input  logic                 overrun_clr_i
);

  localparam logic [ADDR_BITS-1:0] LastAddr  = ADDR_BITS'(FRAME_LEN - 1);
  localparam int unsigned          DrainBits = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DrainBits-1:0] DrainLast = DrainBits'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_BITS-1:0]  r_wcnt;
  logic                  r_wren;
  logic [ADDR_BITS-1:0]  r_waddr;
  logic [DATA_BITS-1:0]  r_wdata;
  logic                  r_sel;
  logic                  r_frame_ready;
  logic                  r_overrun;
  logic [ADDR_BITS-1:0]  r_rcnt;
  logic [DrainBits-1:0]  r_dcnt;
  logic [RD_LAT-1:0]     r_vpipe;
  logic [RD_LAT-1:0]     r_lpipe;

  logic w_frame_done;
  logic w_start_ok;
  logic w_swap;
  logic w_drop;
  logic w_issue;
  logic w_issue_last;

  // Completion is seen in the cycle the final write is presented to the buffer.
  assign w_frame_done = r_wren && (r_waddr == LastAddr);
  assign w_start_ok   = (r_state == StIdle) && rd_start_i && r_frame_ready;
  assign w_swap       = w_frame_done && (r_state == StIdle) && !r_frame_ready;
  assign w_drop       = w_frame_done && !w_swap;
  assign w_issue      = (r_state == StRead);
  assign w_issue_last = w_issue && (r_rcnt == LastAddr);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start_ok) w_state_next = StRead;
      StRead:  if (r_rcnt == LastAddr) w_state_next = StDrain;
      StDrain: if (r_dcnt == DrainLast) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_wcnt        <= '0;
      r_wren        <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_sel         <= 1'b0;
      r_frame_ready <= 1'b0;
      r_overrun     <= 1'b0;
      r_rcnt        <= '0;
      r_dcnt        <= '0;
      r_vpipe       <= '0;
      r_lpipe       <= '0;
    end else begin
      r_state <= w_state_next;

      r_wren <= sample_valid_i;
      if (sample_valid_i) begin
        r_waddr <= r_wcnt;
        r_wdata <= sample_i;
        r_wcnt  <= (r_wcnt == LastAddr) ? '0 : r_wcnt + 1'b1;
      end

      if (w_swap) begin
        r_sel         <= ~r_sel;
        r_frame_ready <= 1'b1;
      end else if (w_start_ok) begin
        r_frame_ready <= 1'b0;
      end

      // Set has priority over clear.
      if (w_drop) r_overrun <= 1'b1;
      else if (overrun_clr_i) r_overrun <= 1'b0;

      if (w_start_ok) r_rcnt <= '0;
      else if (w_issue && (r_rcnt != LastAddr)) r_rcnt <= r_rcnt + 1'b1;

      if (r_state == StDrain) r_dcnt <= r_dcnt + 1'b1;
      else r_dcnt <= '0;

      r_vpipe[0] <= w_issue;
      r_lpipe[0] <= w_issue_last;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

  assign buff_wren_o   = r_wren;
  assign buff_waddr_o  = r_waddr;
  assign buff_wdata_o  = r_wdata;
  assign buff_sel_o    = r_sel;
  assign buff_raddr_o  = w_issue ? r_rcnt : '0;
  assign frame_ready_o = r_frame_ready;
  assign rd_busy_o     = (r_state != StIdle);
  assign rd_valid_o    = r_vpipe[RD_LAT-1];
  assign rd_last_o     = r_lpipe[RD_LAT-1];
  assign rd_data_o     = r_vpipe[RD_LAT-1] ? buff_rdata_i : '0;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with FRAME_LEN=8, RD_LAT=2 and a RAM model returning addr+100.
module tb_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid_i;
  logic [15:0] sample_i;
  logic [15:0] buff_wdata_o;
  logic [9:0]  buff_waddr_o;
  logic        buff_wren_o;
  logic        buff_sel_o;
  logic [9:0]  buff_raddr_o;
  logic [15:0] buff_rdata_i;
  logic        rd_start_i;
  logic        frame_ready_o;
  logic        rd_busy_o;
  logic        rd_valid_o;
  logic [15:0] rd_data_o;
  logic        rd_last_o;
  logic        overrun_o;
  logic        overrun_clr_i;

  int n_pass  = 0;
  int n_total = 0;

  pingpong_ctrl #(
    .DATA_BITS(16),
    .ADDR_BITS(10),
    .FRAME_LEN(8),
    .RD_LAT   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid_i(sample_valid_i),
    .sample_i      (sample_i),
    .buff_wdata_o  (buff_wdata_o),
    .buff_waddr_o  (buff_waddr_o),
    .buff_wren_o   (buff_wren_o),
    .buff_sel_o    (buff_sel_o),
    .buff_raddr_o  (buff_raddr_o),
    .buff_rdata_i  (buff_rdata_i),
    .rd_start_i    (rd_start_i),
    .frame_ready_o (frame_ready_o),
    .rd_busy_o     (rd_busy_o),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_last_o     (rd_last_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency RAM: data = address + 100.
  logic [9:0] r_a1 = '0, r_a2 = '0;
  always @(posedge clk) begin
    r_a1 <= buff_raddr_o;
    r_a2 <= r_a1;
  end
  assign buff_rdata_i = {6'b0, r_a2} + 16'd100;

  typedef struct {
    logic        sv;
    logic [15:0] smp;
    logic        e_wren;
    logic [9:0]  e_waddr;
    logic [15:0] e_wdata;
    logic        e_sel;
    logic        e_fr;
  } vec_t;

  vec_t vecs[24];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Strobes n samples (base, base+1, ...) with gap idle cycles after each.
  task automatic send_frame(input int n, input int gap, input int base);
    for (int i = 0; i < n; i++) begin
      sample_valid_i = 1'b1;
      sample_i       = 16'(base + i);
      step();
      sample_valid_i = 1'b0;
      repeat (gap) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    logic [15:0] last_data;

    // Frame 1: one strobe every 3 cycles, samples 1..8.
    for (int i = 0; i < 24; i++) begin
      vecs[i].sv      = (i % 3 == 0);
      vecs[i].smp     = 16'(i / 3 + 1);
      vecs[i].e_wren  = (i % 3 == 1);
      vecs[i].e_waddr = (i >= 1) ? 10'((i - 1) / 3) : 10'd0;
      vecs[i].e_wdata = (i >= 1) ? 16'((i - 1) / 3 + 1) : 16'd0;
      vecs[i].e_sel   = (i >= 23);
      vecs[i].e_fr    = (i >= 23);
    end

    rst = 1'b1; sample_valid_i = 1'b0; sample_i = '0; rd_start_i = 1'b0; overrun_clr_i = 1'b0;
    step();
    step();
    check("rst_wren", buff_wren_o, 0);
    check("rst_sel", buff_sel_o, 0);
    check("rst_fr", frame_ready_o, 0);
    check("rst_busy", rd_busy_o, 0);
    check("rst_valid", rd_valid_o, 0);
    check("rst_ovr", overrun_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      sample_valid_i = vecs[i].sv;
      sample_i       = vecs[i].smp;
      check($sformatf("t%0d_wren", i), buff_wren_o, vecs[i].e_wren);
      if (vecs[i].e_wren) begin
        check($sformatf("t%0d_waddr", i), buff_waddr_o, vecs[i].e_waddr);
        check($sformatf("t%0d_wdata", i), buff_wdata_o, vecs[i].e_wdata);
      end
      check($sformatf("t%0d_sel", i), buff_sel_o, vecs[i].e_sel);
      check($sformatf("t%0d_fr", i), frame_ready_o, vecs[i].e_fr);
      step();
    end
    sample_valid_i = 1'b0;
    check("f1_ovr", overrun_o, 0);

    // Sweep of the full bank.
    rd_start_i = 1'b1;
    check("sw_fr_before", frame_ready_o, 1);
    check("sw_busy_before", rd_busy_o, 0);
    step();
    rd_start_i = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (j == 0) check("sw_fr_cleared", frame_ready_o, 0);
      if (j < 8) check($sformatf("sw%0d_raddr", j), buff_raddr_o, j);
      check($sformatf("sw%0d_valid", j), rd_valid_o, (j >= 2 && j < 10));
      if (j >= 2 && j < 10) check($sformatf("sw%0d_data", j), rd_data_o, 100 + j - 2);
      check($sformatf("sw%0d_last", j), rd_last_o, (j == 9));
      check($sformatf("sw%0d_busy", j), rd_busy_o, (j < 10));
      step();
    end

    // Frame 2 unread-free: swap back to bank 0.
    send_frame(8, 1, 200);
    check("f2_sel", buff_sel_o, 0);
    check("f2_fr", frame_ready_o, 1);
    check("f2_ovr", overrun_o, 0);

    // Frame 3 while frame_ready: overrun, no toggle.
    send_frame(8, 1, 300);
    check("f3_ovr", overrun_o, 1);
    check("f3_sel", buff_sel_o, 0);
    check("f3_fr", frame_ready_o, 1);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("f3_ovr_clr", overrun_o, 0);

    // Back-to-back strobes during a sweep; first completion lands in READ.
    rd_start_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample_valid_i = 1'b1;
      sample_i       = 16'(400 + i);
      step();
      rd_start_i = 1'b0;
      if (i == 8) begin
        check("bb_ovr", overrun_o, 1);
        check("bb_sel_stable", buff_sel_o, 0);
      end
    end
    sample_valid_i = 1'b0;
    step();
    check("bb2_sel", buff_sel_o, 1);
    check("bb2_fr", frame_ready_o, 1);
    check("bb2_ovr_sticky", overrun_o, 1);
    check("bb2_busy", rd_busy_o, 0);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("bb_ovr_clr", overrun_o, 0);

    // Completion in the same cycle as an accepted rd_start_i.
    send_frame(7, 0, 500);
    sample_valid_i = 1'b1;
    sample_i       = 16'd507;
    step();
    sample_valid_i = 1'b0;
    rd_start_i     = 1'b1;
    check("sim_wren_last", buff_waddr_o, 7);
    step();
    rd_start_i = 1'b0;
    check("sim_ovr", overrun_o, 1);
    check("sim_sel", buff_sel_o, 1);
    check("sim_fr", frame_ready_o, 0);
    check("sim_busy", rd_busy_o, 1);
    check("sim_raddr0", buff_raddr_o, 0);
    nv = 0;
    last_data = '0;
    for (int j = 1; j < 12; j++) begin
      step();
      if (rd_valid_o) nv++;
      if (rd_last_o) last_data = rd_data_o;
    end
    check("sim_nvalid", nv, 8);
    check("sim_last_data", last_data, 107);
    check("sim_busy_end", rd_busy_o, 0);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;

    // Reset mid-READ at raddr 3.
    send_frame(8, 0, 600);
    step();
    check("r_sel", buff_sel_o, 0);
    check("r_fr", frame_ready_o, 1);
    rd_start_i = 1'b1;
    step();
    rd_start_i = 1'b0;
    repeat (3) step();
    check("r_raddr3", buff_raddr_o, 3);
    check("r_valid_pre", rd_valid_o, 1);
    rst = 1'b1;
    step();
    check("r_raddr", buff_raddr_o, 0);
    check("r_busy", rd_busy_o, 0);
    check("r_valid", rd_valid_o, 0);
    check("r_data", rd_data_o, 0);
    check("r_last", rd_last_o, 0);
    check("r_fr0", frame_ready_o, 0);
    check("r_sel0", buff_sel_o, 0);
    check("r_wren0", buff_wren_o, 0);
    check("r_ovr0", overrun_o, 0);
    rst = 1'b0;
    step();
    check("r_valid_after", rd_valid_o, 0);
    sample_valid_i = 1'b1;
    sample_i       = 16'd700;
    step();
    sample_valid_i = 1'b0;
    check("r_new_wren", buff_wren_o, 1);
    check("r_new_waddr", buff_waddr_o, 0);
    check("r_new_wdata", buff_wdata_o, 700);
    send_frame(7, 1, 701);
    check("r_new_sel", buff_sel_o, 1);
    check("r_new_fr", frame_ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
